// File: rtl/alu_serial_seq_pkg.sv
// alu_serial_seq_pkg: opcode constants, FSM encoding and opcode helpers
// shared by the serial ALU and its bit slice.
package alu_serial_seq_pkg;
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_NOR   = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_XNOR  = 4'h6;
    localparam logic [3:0] OP_NAND  = 4'h7;
    localparam logic [3:0] OP_PASSA = 4'h8;
    localparam logic [3:0] OP_PASSB = 4'h9;
    localparam logic [3:0] OP_ZERO  = 4'hA;
    localparam logic [3:0] OP_CMP0  = 4'hB;
    localparam logic [3:0] OP_CMP1  = 4'hC;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_cmp(input logic [3:0] op);
        return op == OP_CMP0 || op == OP_CMP1;
    endfunction

    // Subtraction-like ops feed ~B with a preset carry of 1.
    function automatic logic inverts_b(input logic [3:0] op);
        return op == OP_SUB || is_cmp(op);
    endfunction
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: one-bit combinational ALU cell; arithmetic ops emit sum and
// carry, all others emit their logic function with cout=0.
module alu_bit_slice
    import alu_serial_seq_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       result,
    output logic       cout
);
    logic arith;

    always_comb begin
        arith  = opcode == OP_ADD || opcode == OP_SUB || is_cmp(opcode);
        cout   = arith & ((a & b) | (cin & (a ^ b)));
        result = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_CMP0, OP_CMP1: result = a ^ b ^ cin;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_NOR:   result = ~(a | b);
            OP_XOR:   result = a ^ b;
            OP_XNOR:  result = ~(a ^ b);
            OP_NAND:  result = ~(a & b);
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            default:  result = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU, one bit per cycle LSB first through a
// shared bit slice; done pulses once when the registered result is valid.
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, next;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic             carry, last, bit_r, bit_c;

    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;

    alu_bit_slice u_slice (
        .opcode(op_q),
        .a     (a_q[cnt]),
        .b     (b_q[cnt] ^ inverts_b(op_q)),
        .cin   (carry),
        .result(bit_r),
        .cout  (bit_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        next = (state == IDLE && start) ? SHIFT :
               (state == SHIFT && last) ? DONE  :
               (state == DONE)          ? IDLE  : state;
    end

    // Flags track the slice output so CMP keeps Z/N of the difference
    // while its stored result bits are forced to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b1;
            flag_n <= 1'b0;
        end else if (state == IDLE && start) begin
            op_q  <= opcode;
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            carry <= inverts_b(opcode);
        end else if (state == SHIFT) begin
            result[cnt] <= is_cmp(op_q) ? 1'b0 : bit_r;
            carry       <= bit_c;
            cnt         <= last ? '0 : cnt + 1'b1;
            flag_c      <= bit_c;
            flag_z      <= (cnt == '0 || flag_z) && !bit_r;
            flag_n      <= bit_r;
        end
    end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: scoreboard bench for the serial ALU; expected results
// come from a word-level reference model pushed at start, popped at done.
module tb_alu_serial_seq;
    import alu_serial_seq_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   opcode;
    logic [W-1:0] a, b, result;
    logic         busy, done, flag_c, flag_z, flag_n;
    int           checks = 0;
    int           errors = 0;
    exp_t         sbq[$];

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n)
    );

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [3:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        exp_t         e;
        s = '0;
        r = '0;
        case (op)
            OP_ADD: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; end
            OP_SUB, OP_CMP0, OP_CMP1: begin
                s = {1'b0, x} + {1'b0, ~y} + 1;
                r = s[W-1:0];
            end
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_NOR:   r = ~(x | y);
            OP_XOR:   r = x ^ y;
            OP_XNOR:  r = ~(x ^ y);
            OP_NAND:  r = ~(x & y);
            OP_PASSA: r = x;
            OP_PASSB: r = y;
            default:  r = '0;
        endcase
        e.c = s[W];
        e.z = r == '0;
        e.n = r[W-1];
        e.r = (op == OP_CMP0 || op == OP_CMP1) ? '0 : r;
        return e;
    endfunction

    // Starts one operation and returns the number of edges until done (0 = timeout).
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [3:0] op, output int cyc);
        @(posedge clk); #1;
        a = x; b = y; opcode = op; start = 1'b1;
        sbq.push_back(model(x, y, op));
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (done) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, flag_c, flag_z, flag_n} !== {2'b00, 8'h00, 3'b010}) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b res=%h c=%b z=%b n=%b want 0 0 00 0 1 0",
                     busy, done, result, flag_c, flag_z, flag_n);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int   cyc;
        exp_t e;
        run_op(8'hFF, 8'h01, OP_ADD, cyc);
        e = sbq.pop_front();
        checks++;
        if (cyc !== 9) begin
            errors++; $display("FAIL add_latency got %0d want 9", cyc);
        end
        checks++;
        if ({result, flag_c, flag_z, flag_n} !== e || e !== {8'h00, 3'b110}) begin
            errors++;
            $display("FAIL add_result got %h c%b z%b n%b want %h", result, flag_c, flag_z, flag_n, e);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_single_pulse got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_sub_cmp();
        int   cyc;
        exp_t e;
        run_op(8'h05, 8'h07, OP_SUB, cyc);
        e = sbq.pop_front();
        checks++;
        if ({result, flag_c, flag_z, flag_n} !== {8'hFE, 3'b001}) begin
            errors++;
            $display("FAIL sub_result got %h c%b z%b n%b want fe c0 z0 n1", result, flag_c, flag_z, flag_n);
        end
        run_op(8'h3C, 8'h3C, OP_CMP0, cyc);
        e = sbq.pop_front();
        checks++;
        if ({result, flag_c, flag_z, flag_n} !== e || cyc !== 9) begin
            errors++;
            $display("FAIL cmp_equal got %h c%b z%b n%b cyc %0d want %h cyc 9",
                     result, flag_c, flag_z, flag_n, cyc, e);
        end
        run_op(8'h10, 8'h90, OP_CMP1, cyc);
        e = sbq.pop_front();
        checks++;
        if ({result, flag_c, flag_z, flag_n} !== e) begin
            errors++;
            $display("FAIL cmp_borrow got %h c%b z%b n%b want %h", result, flag_c, flag_z, flag_n, e);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        run_op(8'hF0, 8'hCC, OP_NAND, cyc);
        e = sbq.pop_front();
        checks++;
        if ({result, flag_c} !== {8'h3F, 1'b0} || {result, flag_c, flag_z, flag_n} !== e) begin
            errors++; $display("FAIL nand_result got %h c%b want 3f c0", result, flag_c);
        end
        run_op(8'hAA, 8'h0F, OP_XOR, cyc);
        e = sbq.pop_front();
        checks++;
        if (result !== 8'hA5 || cyc !== 9 || {result, flag_c, flag_z, flag_n} !== e) begin
            errors++; $display("FAIL b2b_xor got %h cyc %0d want a5 cyc 9", result, cyc);
        end
    endtask

    task automatic test_all_ops();
        int           cyc;
        exp_t         e;
        logic [W-1:0] x, y;
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 2; k++) begin
                x = W'($urandom);
                y = W'($urandom);
                run_op(x, y, 4'(op), cyc);
                e = sbq.pop_front();
                checks++;
                if ({result, flag_c, flag_z, flag_n} !== e || cyc !== 9) begin
                    errors++;
                    $display("FAIL op_%0d a=%h b=%h got %h c%b z%b n%b cyc %0d want %h cyc 9",
                             op, x, y, result, flag_c, flag_z, flag_n, cyc, e);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int   pulses = 0;
        exp_t e;
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; opcode = OP_ADD; start = 1'b1;
        sbq.push_back(model(8'h12, 8'h34, OP_ADD));
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (i == 3) begin a = 8'hFF; b = 8'hFF; opcode = OP_XOR; start = 1'b1; end
            if (i == 4) start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    e = sbq.pop_front();
                    checks++;
                    if ({result, flag_c, flag_z, flag_n} !== e || i !== 9) begin
                        errors++;
                        $display("FAIL ignore_start_result got %h at %0d want %h at 9", result, i, e);
                    end
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL ignore_start_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int   pulses = 0;
        exp_t e;
        @(posedge clk); #1;
        a = 8'h77; b = 8'h11; opcode = OP_ADD; start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (i == 5) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({busy, done, result, flag_c, flag_z, flag_n} !== {2'b00, 8'h00, 3'b010}) begin
                    errors++;
                    $display("FAIL reset_mid_state got busy=%b done=%b res=%h c=%b z=%b n=%b want 0 0 00 0 1 0",
                             busy, done, result, flag_c, flag_z, flag_n);
                end
            end
            if (i == 7) begin
                rst = 1'b0;
                a = 8'h10; b = 8'h20; opcode = OP_ADD; start = 1'b1;
                sbq.push_back(model(8'h10, 8'h20, OP_ADD));
            end
            if (i == 8) start = 1'b0;
            if (done) begin
                pulses++;
                e = sbq.pop_front();
                checks++;
                if (result !== 8'h30 || {result, flag_c, flag_z, flag_n} !== e || i !== 16) begin
                    errors++; $display("FAIL post_reset_add got %h at %0d want 30 at 16", result, i);
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL reset_abort_pulses got %0d want 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_back_to_back();
        test_all_ops();
        test_start_ignored();
        test_reset_mid();
        checks++;
        if (sbq.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port opcode, input, 4, operation select, same encoding as the bit-slice ALU.
REQ-006 SHALL have port a, input, WIDTH, operand A.
REQ-007 SHALL have port b, input, WIDTH, operand B.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress (SHIFT or DONE).
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking a valid result.
REQ-010 SHALL have port result, output, WIDTH, registered result.
REQ-011 SHALL have port flag_c, output, 1, final carry-out; 1 on SUB/CMP means no borrow.
REQ-012 SHALL have port flag_z, output, 1, high when result is all zeros; for CMP, high when A equals B.
REQ-013 SHALL have port flag_n, output, 1, MSB of result; for CMP, MSB of A-B.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL, in IDLE with start=1, latch a, b and opcode, clear the bit counter, preset the carry flop, and enter SHIFT.
REQ-016 SHALL preset the carry flop to 1 for opcodes 0001, 1011 and 1100, and to 0 otherwise.
REQ-017 SHALL process one bit per SHIFT cycle, LSB first: feed A[i] and B[i] (B[i] inverted for 0001/1011/1100) plus the carry flop into the bit slice; store the slice result in bit i; update the carry flop.
REQ-018 SHALL go from SHIFT to DONE after the cycle with counter=WIDTH-1; total SHIFT cycles = WIDTH.
REQ-019 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE; done rises WIDTH+1 cycles after the accepting start edge.
REQ-020 SHALL ignore start while busy; latched operands are unaffected by input changes after acceptance.
REQ-021 SHALL accept start in the cycle after DONE (back-to-back operation allowed).
REQ-022 SHALL decode opcodes as follows: 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 NOR; 0101 XOR; 0110 XNOR; 0111 NAND; 1000 pass A; 1001 pass B; 1010 zero.
REQ-023 SHALL treat 1011 and 1100 as CMP: compute A-B for the flags, force every result bit to 0, and keep flag_z/flag_n computed from the internal difference.
REQ-024 SHALL treat opcodes 1101-1111 as zero: result=0, flag_c=0.
REQ-025 SHALL force flag_c=0 for all non-arithmetic opcodes (0010-1010); flag_c SHALL be the carry out of bit WIDTH-1 and SHALL discard any wrap beyond WIDTH.
REQ-026 SHALL hold result and all flags stable from DONE until the next accepted start; they may change during SHIFT.

Reset
REQ-027 SHALL, on rst, immediately force state=IDLE, busy=0, done=0, result=0, flag_c=0, flag_z=1, flag_n=0, counter=0, and carry flop=0.
REQ-028 SHALL abort any operation in progress on rst without producing a done pulse, and SHALL accept start on the first clk edge after rst deasserts.

Structure
REQ-029 SHALL place opcode constants (OP_ADD..OP_ZERO, OP_CMP0/OP_CMP1) and FSM state encodings in the shared ALU package.
REQ-030 SHALL instantiate a single combinational sub-module, alu_bit_slice: inputs opcode, a, b, cin; outputs result, cout; it contains no B-inversion or carry-preset logic.
REQ-031 SHALL keep the counter width at clog2(WIDTH).

Verification (WIDTH=8)
REQ-032 SHALL cover ADD: a=0xFF, b=0x01, op=0000 -> done at start+9, result=0x00, C=1, Z=1, N=0.
REQ-033 SHALL cover SUB: a=0x05, b=0x07, op=0001 -> result=0xFE, C=0, Z=0, N=1.
REQ-034 SHALL cover CMP: a=0x3C, b=0x3C, op=1011 -> result=0x00, C=1, Z=1, N=0.
REQ-035 SHALL cover NAND then back-to-back XOR: 0xF0 NAND 0xCC -> 0x3F, C=0; then start one cycle after done with 0xAA XOR 0x0F -> 0xA5.
REQ-036 SHALL cover start pulsed again mid-SHIFT with different operands -> ignored; the original result is returned, and done pulses exactly once.
REQ-037 SHALL cover rst asserted at SHIFT bit 4 -> no done; outputs equal reset values; a new ADD 0x10+0x20 -> 0x30.
